// File: rtl/master_seq_ctrl.sv
// Bus master for the CIM array: streams per-CIM parameters, epoch samples and inference start.
// Optional per-CIM parameter checksum op is enabled by defining MASTER_PARAM_CHECKSUM_EN.
module master_seq_ctrl #(
  parameter int NUM_CIMS       = 64,
  parameter int BUS_OP_WIDTH   = 4,
  parameter int BUS_DATA_WIDTH = 16,
  parameter int PARAMS_PER_CIM = 512,
  parameter int SIGNAL_LEN     = 3000,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int READY_TIMEOUT  = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_param_load,
  input  logic                        new_sleep_epoch,
  input  logic                        all_cims_ready,
  output logic                        mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  input  logic                        mem_rd_valid,
  input  logic [BUS_DATA_WIDTH-1:0]   mem_rd_data,
  input  logic                        adc_sample_valid,
  input  logic [BUS_DATA_WIDTH-1:0]   adc_sample,
  output logic                        bus_drive,
  output logic [BUS_OP_WIDTH-1:0]     bus_op,
  output logic [BUS_DATA_WIDTH-1:0]   bus_data,
  output logic [$clog2(NUM_CIMS)-1:0] bus_target,
  output logic                        busy,
  output logic                        error,
  output logic                        epoch_overrun
);

  localparam int TGT_W  = $clog2(NUM_CIMS);
  localparam int WORD_W = $clog2(PARAMS_PER_CIM + 1);
  localparam int SAMP_W = $clog2(SIGNAL_LEN + 1);
  localparam int TMO_W  = $clog2(READY_TIMEOUT + 1);

  localparam logic [BUS_OP_WIDTH-1:0] OP_NOP         = BUS_OP_WIDTH'(0);
  localparam logic [BUS_OP_WIDTH-1:0] OP_PARAM_START = BUS_OP_WIDTH'(1);
  localparam logic [BUS_OP_WIDTH-1:0] OP_PARAM_WORD  = BUS_OP_WIDTH'(2);
  localparam logic [BUS_OP_WIDTH-1:0] OP_SIG_START   = BUS_OP_WIDTH'(3);
  localparam logic [BUS_OP_WIDTH-1:0] OP_SIG_WORD    = BUS_OP_WIDTH'(4);
  localparam logic [BUS_OP_WIDTH-1:0] OP_INFER_START = BUS_OP_WIDTH'(5);
`ifdef MASTER_PARAM_CHECKSUM_EN
  localparam logic [BUS_OP_WIDTH-1:0] OP_PARAM_CHECK = BUS_OP_WIDTH'(6);
`endif

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(PARAMS_PER_CIM - 1);
  localparam logic [TGT_W-1:0]  LAST_CIM  = TGT_W'(NUM_CIMS - 1);
  localparam logic [SAMP_W-1:0] LAST_SAMP = SAMP_W'(SIGNAL_LEN - 1);
  localparam logic [TMO_W-1:0]  LAST_TMO  = TMO_W'(READY_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, P_START, P_REQ, P_WAIT, P_CHECK, P_NEXT, S_START, S_STREAM, RDY_WAIT
  } state_t;

  state_t                     state, state_n;
  logic [WORD_W-1:0]          word_idx, word_n;
  logic [TGT_W-1:0]           cim_idx, cim_n;
  logic [SAMP_W-1:0]          samp_cnt, samp_n;
  logic [TMO_W-1:0]           tmo_cnt, tmo_n;
  logic                       infer_flag, infer_n;
  logic                       err_n, ovr_n, rd_n;
  logic [MEM_ADDR_WIDTH-1:0]  addr_n;
  logic                       drv_n;
  logic [BUS_OP_WIDTH-1:0]    op_n;
  logic [BUS_DATA_WIDTH-1:0]  dat_n;
  logic [TGT_W-1:0]           tgt_n;

`ifdef MASTER_PARAM_CHECKSUM_EN
  logic [BUS_DATA_WIDTH-1:0]  csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (state == P_START) begin
      csum <= '0;
    end else if (state == P_WAIT && mem_rd_valid) begin
      csum <= csum + mem_rd_data;
    end
  end
`endif

  always_comb begin
    state_n = state;
    word_n  = word_idx;
    cim_n   = cim_idx;
    samp_n  = samp_cnt;
    tmo_n   = '0;
    infer_n = infer_flag;
    err_n   = error;
    ovr_n   = 1'b0;
    rd_n    = 1'b0;
    addr_n  = '0;
    drv_n   = 1'b0;
    op_n    = OP_NOP;
    dat_n   = '0;
    tgt_n   = '0;

    // Epoch requests that cannot be honoured are reported, never queued.
    if (state != IDLE) ovr_n = new_sleep_epoch;

    case (state)
      IDLE: begin
        if (start_param_load) begin
          state_n = P_START;
          cim_n   = '0;
          word_n  = '0;
          ovr_n   = new_sleep_epoch;
        end else if (new_sleep_epoch) begin
          state_n = S_START;
          samp_n  = '0;
        end
      end
      P_START: begin
        drv_n   = 1'b1;
        op_n    = OP_PARAM_START;
        tgt_n   = cim_idx;
        state_n = P_REQ;
      end
      P_REQ: begin
        rd_n    = 1'b1;
        addr_n  = MEM_ADDR_WIDTH'(32'(cim_idx) * 32'(PARAMS_PER_CIM) + 32'(word_idx));
        state_n = P_WAIT;
      end
      P_WAIT: begin
        if (mem_rd_valid) begin
          drv_n  = 1'b1;
          op_n   = OP_PARAM_WORD;
          dat_n  = mem_rd_data;
          tgt_n  = cim_idx;
          word_n = word_idx + WORD_W'(1);
          if (word_idx == LAST_WORD) begin
`ifdef MASTER_PARAM_CHECKSUM_EN
            state_n = P_CHECK;
`else
            state_n = P_NEXT;
`endif
          end else begin
            state_n = P_REQ;
          end
        end
      end
`ifdef MASTER_PARAM_CHECKSUM_EN
      P_CHECK: begin
        drv_n   = 1'b1;
        op_n    = OP_PARAM_CHECK;
        dat_n   = csum;
        tgt_n   = cim_idx;
        state_n = P_NEXT;
      end
`endif
      P_NEXT: begin
        if (cim_idx == LAST_CIM) begin
          state_n = RDY_WAIT;
        end else begin
          cim_n   = cim_idx + TGT_W'(1);
          word_n  = '0;
          state_n = P_START;
        end
      end
      S_START: begin
        drv_n   = 1'b1;
        op_n    = OP_SIG_START;
        dat_n   = BUS_DATA_WIDTH'(SIGNAL_LEN);
        state_n = S_STREAM;
      end
      S_STREAM: begin
        if (adc_sample_valid) begin
          drv_n  = 1'b1;
          op_n   = OP_SIG_WORD;
          dat_n  = adc_sample;
          samp_n = samp_cnt + SAMP_W'(1);
          if (samp_cnt == LAST_SAMP) begin
            state_n = RDY_WAIT;
            infer_n = 1'b1;
          end
        end
      end
      RDY_WAIT: begin
        if (all_cims_ready) begin
          if (infer_flag) begin
            drv_n = 1'b1;
            op_n  = OP_INFER_START;
          end
          infer_n = 1'b0;
          state_n = IDLE;
        end else if (tmo_cnt == LAST_TMO) begin
          err_n   = 1'b1;
          infer_n = 1'b0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo_cnt + TMO_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      word_idx      <= '0;
      cim_idx       <= '0;
      samp_cnt      <= '0;
      tmo_cnt       <= '0;
      infer_flag    <= 1'b0;
      error         <= 1'b0;
      epoch_overrun <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      bus_drive     <= 1'b0;
      bus_op        <= '0;
      bus_data      <= '0;
      bus_target    <= '0;
    end else begin
      state         <= state_n;
      word_idx      <= word_n;
      cim_idx       <= cim_n;
      samp_cnt      <= samp_n;
      tmo_cnt       <= tmo_n;
      infer_flag    <= infer_n;
      error         <= err_n;
      epoch_overrun <= ovr_n;
      mem_rd_en     <= rd_n;
      mem_addr      <= addr_n;
      bus_drive     <= drv_n;
      bus_op        <= op_n;
      bus_data      <= dat_n;
      bus_target    <= tgt_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_master_seq_ctrl.sv
// Directed bench for master_seq_ctrl with a 2-cycle-latency parameter memory (data = addr+1).
module tb_master_seq_ctrl;
  localparam int NC = 2, PPC = 4, SL = 5, RT = 16;

  logic        clk = 1'b0;
  logic        rst_n, start_param_load, new_sleep_epoch, all_cims_ready;
  logic        mem_rd_en, mem_rd_valid, adc_sample_valid;
  logic [15:0] mem_addr, mem_rd_data, adc_sample, bus_data;
  logic        bus_drive, busy, error, epoch_overrun;
  logic [3:0]  bus_op;
  logic        bus_target;

  master_seq_ctrl #(
    .NUM_CIMS(NC), .BUS_OP_WIDTH(4), .BUS_DATA_WIDTH(16), .PARAMS_PER_CIM(PPC),
    .SIGNAL_LEN(SL), .MEM_ADDR_WIDTH(16), .READY_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_param_load(start_param_load),
    .new_sleep_epoch(new_sleep_epoch), .all_cims_ready(all_cims_ready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .adc_sample_valid(adc_sample_valid),
    .adc_sample(adc_sample), .bus_drive(bus_drive), .bus_op(bus_op),
    .bus_data(bus_data), .bus_target(bus_target), .busy(busy), .error(error),
    .epoch_overrun(epoch_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0]  op_q[$];
  logic [15:0] dat_q[$];
  logic        tgt_q[$];
  logic [15:0] addr_q[$];
  logic [3:0]  eop[$];
  logic [15:0] edat[$];
  logic        etgt[$];
  int          idle_viol = 0;
  int          ovr_pulses = 0;

  logic        p0_v = 1'b0, p1_v = 1'b0;
  logic [15:0] p0_d = '0, p1_d = '0;

  // Bus/memory monitor plus the memory responder, all sampled on the falling edge.
  always @(negedge clk) begin
    if (bus_drive) begin
      op_q.push_back(bus_op);
      dat_q.push_back(bus_data);
      tgt_q.push_back(bus_target);
    end else if (bus_op != 4'd0 || bus_data != 16'd0 || bus_target != 1'b0) begin
      idle_viol++;
    end
    if (mem_rd_en) addr_q.push_back(mem_addr);
    if (epoch_overrun) ovr_pulses++;
    mem_rd_valid = p1_v;
    mem_rd_data  = p1_d;
    p1_v = p0_v;
    p1_d = p0_d;
    p0_v = mem_rd_en;
    p0_d = mem_addr + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    op_q.delete(); dat_q.delete(); tgt_q.delete(); addr_q.delete();
    eop.delete(); edat.delete(); etgt.delete();
  endtask

  task automatic exp_tx(input logic [3:0] o, input logic [15:0] d, input logic t);
    eop.push_back(o);
    edat.push_back(d);
    etgt.push_back(t);
  endtask

  task automatic expect_param();
    logic [15:0] sum;
    for (int t = 0; t < NC; t++) begin
      exp_tx(4'd1, 16'd0, 1'(t));
      sum = '0;
      for (int w = 0; w < PPC; w++) begin
        exp_tx(4'd2, 16'(t * PPC + w + 1), 1'(t));
        sum = sum + 16'(t * PPC + w + 1);
      end
`ifdef MASTER_PARAM_CHECKSUM_EN
      exp_tx(4'd6, sum, 1'(t));
`endif
    end
  endtask

  task automatic check_log(input string pfx);
    chk({pfx, "_count"}, op_q.size(), eop.size());
    for (int i = 0; i < eop.size() && i < op_q.size(); i++)
      chk({pfx, "_tx"}, {op_q[i], dat_q[i], tgt_q[i]}, {eop[i], edat[i], etgt[i]});
  endtask

  task automatic check_addrs(input string pfx);
    chk({pfx, "_addr_count"}, addr_q.size(), NC * PPC);
    for (int i = 0; i < addr_q.size(); i++)
      chk({pfx, "_addr"}, addr_q[i], i);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_drive"}, bus_drive, 0);
    chk({pfx, "_op"}, bus_op, 0);
    chk({pfx, "_data"}, bus_data, 0);
    chk({pfx, "_target"}, bus_target, 0);
    chk({pfx, "_rd_en"}, mem_rd_en, 0);
    chk({pfx, "_addr"}, mem_addr, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_error"}, error, 0);
    chk({pfx, "_overrun"}, epoch_overrun, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic pulse_start();
    start_param_load = 1'b1;
    @(negedge clk);
    start_param_load = 1'b0;
  endtask

  task automatic pulse_epoch();
    new_sleep_epoch = 1'b1;
    @(negedge clk);
    new_sleep_epoch = 1'b0;
  endtask

  initial begin
    int n;
    int n_sig, n_inf;
    rst_n = 1'b0; start_param_load = 1'b0; new_sleep_epoch = 1'b0;
    all_cims_ready = 1'b0; adc_sample_valid = 1'b0; adc_sample = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Parameter load, two CIMs of four words each
    all_cims_ready = 1'b1;
    clear_logs();
    pulse_start();
    wait_idle("param_idle");
    @(negedge clk);
    expect_param();
    check_log("param");
    check_addrs("param");
    chk("param_error", error, 0);
    chk("param_overrun", ovr_pulses, 0);

    // Signal load with gaps between samples, ready arriving 3 cycles later
    all_cims_ready = 1'b0;
    clear_logs();
    pulse_epoch();
    @(negedge clk);
    for (int i = 0; i < SL; i++) begin
      adc_sample_valid = 1'b1;
      adc_sample = 16'h0011 + 16'(i);
      @(negedge clk);
      adc_sample_valid = 1'b0;
      repeat (2) @(negedge clk);
    end
    chk("sig_busy_before_ready", busy, 1);
    repeat (3) @(negedge clk);
    all_cims_ready = 1'b1;
    wait_idle("sig_idle");
    @(negedge clk);
    exp_tx(4'd3, 16'd5, 1'b0);
    for (int i = 0; i < SL; i++) exp_tx(4'd4, 16'h0011 + 16'(i), 1'b0);
    exp_tx(4'd5, 16'd0, 1'b0);
    check_log("sig");
    chk("sig_error", error, 0);
    chk("sig_overrun", ovr_pulses, 0);

    // Simultaneous start and epoch, then an epoch request mid-load
    clear_logs();
    start_param_load = 1'b1;
    new_sleep_epoch = 1'b1;
    @(negedge clk);
    start_param_load = 1'b0;
    new_sleep_epoch = 1'b0;
    repeat (6) @(negedge clk);
    pulse_epoch();
    wait_idle("coll_idle");
    @(negedge clk);
    expect_param();
    check_log("coll");
    chk("coll_overrun_pulses", ovr_pulses, 2);

    // Ready never arrives: timeout after 16 cycles in the wait state
    all_cims_ready = 1'b0;
    clear_logs();
    pulse_epoch();
    @(negedge clk);
    for (int i = 0; i < SL; i++) begin
      adc_sample_valid = 1'b1;
      adc_sample = 16'h0021 + 16'(i);
      @(negedge clk);
    end
    adc_sample_valid = 1'b0;
    repeat (RT - 1) @(negedge clk);
    chk("tmo_error_early", error, 0);
    chk("tmo_busy_early", busy, 1);
    @(negedge clk);
    chk("tmo_error", error, 1);
    chk("tmo_busy", busy, 0);
    repeat (4) @(negedge clk);
    n_sig = 0; n_inf = 0;
    for (int i = 0; i < op_q.size(); i++) begin
      if (op_q[i] == 4'd4) n_sig++;
      if (op_q[i] == 4'd5) n_inf++;
    end
    chk("tmo_sig_words", n_sig, SL);
    chk("tmo_no_infer", n_inf, 0);
    chk("tmo_error_sticky", error, 1);

    // Reset while waiting on memory, then a clean restart
    all_cims_ready = 1'b1;
    clear_logs();
    pulse_start();
    n = 0;
    while (mem_rd_en !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_rd_seen", mem_rd_en, 1);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clear_logs();
    repeat (2) @(negedge clk);
    chk("abort_no_tx", op_q.size(), 0);
    pulse_start();
    wait_idle("restart_idle");
    @(negedge clk);
    expect_param();
    check_log("restart");
    check_addrs("restart");
    chk("restart_error", error, 0);
    chk("bus_idle_zero", idle_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
